// File: rtl/w_writeback.sv
// W stage: registers M-stage results, extends load data, and merges a one-entry side-write buffer into the GRF write port.
// Optional feature: define WB_TRACE_EN to print each committed GRF write.
module w_writeback (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [4:0]  i_A3,
  input  logic        i_writeEn,
  input  logic [1:0]  i_wdSel,
  input  logic [31:0] i_aluOut,
  input  logic [31:0] i_memData,
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_addrLow,
  input  logic [2:0]  i_loadType,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_A3,
  input  logic [31:0] i_mdu_WD,
  output logic        o_mdu_ready,
  output logic [4:0]  o_A3,
  output logic [31:0] o_WD,
  output logic        o_writeEn,
  output logic        o_pend,
  output logic [4:0]  o_pendA3,
  output logic [31:0] o_pc
);

  logic [4:0]  a3_q;
  logic        we_q;
  logic [1:0]  wdsel_q;
  logic [31:0] alu_q;
  logic [31:0] ld_q;
  logic [31:0] pc_q;

  logic        buf_v;
  logic [4:0]  buf_a3;
  logic [31:0] buf_wd;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] pipe_wd;
  logic        pipe_eff;
  logic        side_accept;

  // Load extension happens on the M-side so only the final word is registered.
  always_comb begin
    ld_byte = i_memData[{i_addrLow, 3'b000} +: 8];
    ld_half = i_addrLow[1] ? i_memData[31:16] : i_memData[15:0];
    case (i_loadType)
      3'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_ext = {24'd0, ld_byte};
      3'd3:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {16'd0, ld_half};
      default: ld_ext = i_memData;
    endcase
  end

  always_comb begin
    case (wdsel_q)
      2'd1:    pipe_wd = ld_q;
      2'd2:    pipe_wd = pc_q + 32'd8;
      default: pipe_wd = alu_q;
    endcase
  end

  assign pipe_eff    = we_q && (a3_q != 5'd0);
  assign o_mdu_ready = !buf_v;
  assign side_accept = i_mdu_valid && !buf_v;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a3_q    <= 5'd0;
      we_q    <= 1'b0;
      wdsel_q <= 2'd0;
      alu_q   <= 32'd0;
      ld_q    <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      a3_q    <= i_flush ? 5'd0 : i_A3;
      we_q    <= i_flush ? 1'b0 : i_writeEn;
      pc_q    <= i_flush ? 32'd0 : i_pc;
      wdsel_q <= i_wdSel;
      alu_q   <= i_aluOut;
      ld_q    <= ld_ext;
    end
  end

  // Accept and drain never coincide: acceptance requires an empty buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_v  <= 1'b0;
      buf_a3 <= 5'd0;
      buf_wd <= 32'd0;
    end else if (side_accept) begin
      if (i_mdu_A3 != 5'd0) begin
        buf_v  <= 1'b1;
        buf_a3 <= i_mdu_A3;
        buf_wd <= i_mdu_WD;
      end
    end else if (buf_v && !pipe_eff) begin
      buf_v  <= 1'b0;
      buf_a3 <= 5'd0;
      buf_wd <= 32'd0;
    end
  end

  always_comb begin
    o_A3      = a3_q;
    o_WD      = pipe_wd;
    o_writeEn = 1'b0;
    if (pipe_eff) begin
      o_writeEn = 1'b1;
    end else if (buf_v) begin
      o_A3      = buf_a3;
      o_WD      = buf_wd;
      o_writeEn = (buf_a3 != 5'd0);
    end
  end

  assign o_pend   = buf_v;
  assign o_pendA3 = buf_v ? buf_a3 : 5'd0;
  assign o_pc     = pc_q;

`ifdef WB_TRACE_EN
  always @(posedge i_clk) begin
    if (o_writeEn)
      $display("%0t@%08h: $%0d <= %08h", $time, pipe_eff ? pc_q : 32'd0, o_A3, o_WD);
  end
`else
`endif

endmodule

// File: tb/tb_w_writeback.sv
// Directed bench for w_writeback: load extension, PC+8, flush, side-buffer arbitration and reset.
module tb_w_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [4:0]  a3;
  logic        write_en;
  logic [1:0]  wd_sel;
  logic [31:0] alu_out;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [1:0]  addr_low;
  logic [2:0]  load_type;
  logic        mdu_valid;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd;
  logic        mdu_ready;
  logic [4:0]  out_a3;
  logic [31:0] out_wd;
  logic        out_we;
  logic        pend;
  logic [4:0]  pend_a3;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w_writeback dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (flush),
    .i_A3        (a3),
    .i_writeEn   (write_en),
    .i_wdSel     (wd_sel),
    .i_aluOut    (alu_out),
    .i_memData   (mem_data),
    .i_pc        (pc),
    .i_addrLow   (addr_low),
    .i_loadType  (load_type),
    .i_mdu_valid (mdu_valid),
    .i_mdu_A3    (mdu_a3),
    .i_mdu_WD    (mdu_wd),
    .o_mdu_ready (mdu_ready),
    .o_A3        (out_a3),
    .o_WD        (out_wd),
    .o_writeEn   (out_we),
    .o_pend      (pend),
    .o_pendA3    (pend_a3),
    .o_pc        (out_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input logic we, input logic [4:0] d_a3, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] al,
                         input logic [2:0] lt, input logic [31:0] d_pc);
    write_en  = we;
    a3        = d_a3;
    wd_sel    = sel;
    alu_out   = alu;
    mem_data  = mem;
    addr_low  = al;
    load_type = lt;
    pc        = d_pc;
  endtask

  task automatic drive_side(input logic v, input logic [4:0] d_a3, input logic [31:0] wd);
    mdu_valid = v;
    mdu_a3    = d_a3;
    mdu_wd    = wd;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] e_a3, input logic [31:0] e_wd);
    chk({tag, "_we"}, 32'(out_we), 32'(we));
    chk({tag, "_a3"}, 32'(out_a3), 32'(e_a3));
    chk({tag, "_wd"}, out_wd, e_wd);
  endtask

  task automatic chk_buf(input string tag, input logic e_pend, input logic [4:0] e_pa3);
    chk({tag, "_pend"}, 32'(pend), 32'(e_pend));
    chk({tag, "_pend_a3"}, 32'(pend_a3), 32'(e_pa3));
    chk({tag, "_ready"}, 32'(mdu_ready), 32'(!e_pend));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive_m(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0);
    drive_side(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk_port("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_pc", out_pc, 32'd0);
    chk_buf("reset", 1'b0, 5'd0);

    // Load extension variants
    drive_m(1'b1, 5'd5, 2'd1, 32'd0, 32'h80112233, 2'd3, 3'd1, 32'h00000100);
    tick();
    chk_port("lb_a3", 1'b1, 5'd5, 32'hFFFFFF80);
    chk("lb_pc", out_pc, 32'h00000100);
    drive_m(1'b1, 5'd6, 2'd1, 32'd0, 32'h80017FFF, 2'd2, 3'd4, 32'h00000104);
    tick();
    chk_port("lhu_a2", 1'b1, 5'd6, 32'h00008001);
    drive_m(1'b1, 5'd6, 2'd1, 32'd0, 32'h80017FFF, 2'd1, 3'd3, 32'h00000108);
    tick();
    chk("lh_a1_wd", out_wd, 32'h00007FFF);
    drive_m(1'b1, 5'd6, 2'd1, 32'd0, 32'h80112233, 2'd3, 3'd2, 32'h0000010C);
    tick();
    chk("lbu_a3_wd", out_wd, 32'h00000080);
    drive_m(1'b1, 5'd6, 2'd1, 32'd0, 32'h80112233, 2'd0, 3'd1, 32'h00000110);
    tick();
    chk("lb_a0_wd", out_wd, 32'h00000033);
    drive_m(1'b1, 5'd6, 2'd1, 32'd0, 32'h80112233, 2'd0, 3'd6, 32'h00000114);
    tick();
    chk("lw_lt6_wd", out_wd, 32'h80112233);

    // Writeback source select
    drive_m(1'b1, 5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 3'd0, 32'h00003000);
    tick();
    chk_port("pc8", 1'b1, 5'd31, 32'h00003008);
    drive_m(1'b1, 5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 3'd0, 32'hFFFFFFF8);
    tick();
    chk("pc8_wrap_wd", out_wd, 32'd0);
    chk("pc8_wrap_pc", out_pc, 32'hFFFFFFF8);
    drive_m(1'b1, 5'd2, 2'd3, 32'h0000DEAD, 32'd0, 2'd0, 3'd0, 32'd0);
    tick();
    chk("sel3_wd", out_wd, 32'h0000DEAD);

    // Flush captures a bubble
    drive_m(1'b1, 5'd5, 2'd0, 32'h11, 32'd0, 2'd0, 3'd0, 32'h200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_we", 32'(out_we), 32'd0);
    chk("flush_a3", 32'(out_a3), 32'd0);
    chk("flush_pc", out_pc, 32'd0);

    // Side write held off by continuous pipeline writes to $3
    drive_m(1'b1, 5'd3, 2'd0, 32'hAA, 32'd0, 2'd0, 3'd0, 32'h300);
    drive_side(1'b1, 5'd7, 32'h1234);
    chk("side_ready_pre", 32'(mdu_ready), 32'd1);
    tick();
    drive_side(1'b0, 5'd0, 32'd0);
    chk_port("prio1", 1'b1, 5'd3, 32'hAA);
    chk_buf("prio1", 1'b1, 5'd7);
    tick();
    chk_port("prio2", 1'b1, 5'd3, 32'hAA);
    chk_buf("prio2", 1'b1, 5'd7);
    drive_m(1'b0, 5'd3, 2'd0, 32'hAA, 32'd0, 2'd0, 3'd0, 32'h304);
    tick();
    chk_port("bubble", 1'b1, 5'd7, 32'h1234);
    tick();
    chk_port("drained", 1'b0, 5'd3, 32'hAA);
    chk_buf("drained", 1'b0, 5'd0);

    // Back-to-back side writes leave a one-cycle gap
    drive_side(1'b1, 5'd8, 32'h55);
    tick();
    drive_side(1'b1, 5'd9, 32'h66);
    chk_port("b2b_first", 1'b1, 5'd8, 32'h55);
    chk_buf("b2b_first", 1'b1, 5'd8);
    tick();
    chk("b2b_gap_we", 32'(out_we), 32'd0);
    chk_buf("b2b_gap", 1'b0, 5'd0);
    tick();
    drive_side(1'b0, 5'd0, 32'd0);
    chk_port("b2b_second", 1'b1, 5'd9, 32'h66);
    chk_buf("b2b_second", 1'b1, 5'd9);
    tick();
    chk_buf("b2b_end", 1'b0, 5'd0);

    // Side request to $0 is accepted and dropped
    drive_side(1'b1, 5'd0, 32'h77);
    tick();
    drive_side(1'b0, 5'd0, 32'd0);
    chk("side_zero_we", 32'(out_we), 32'd0);
    chk_buf("side_zero", 1'b0, 5'd0);

    // Pipeline write to $0 is suppressed and lets a buffered entry through
    drive_m(1'b1, 5'd0, 2'd0, 32'h99, 32'd0, 2'd0, 3'd0, 32'h400);
    tick();
    chk("pipe_a3_zero_we", 32'(out_we), 32'd0);
    drive_m(1'b1, 5'd3, 2'd0, 32'h33, 32'd0, 2'd0, 3'd0, 32'h404);
    drive_side(1'b1, 5'd4, 32'h44);
    tick();
    drive_side(1'b0, 5'd0, 32'd0);
    drive_m(1'b1, 5'd0, 2'd0, 32'h99, 32'd0, 2'd0, 3'd0, 32'h408);
    chk_buf("zero_fill", 1'b1, 5'd4);
    tick();
    chk_port("zero_drain", 1'b1, 5'd4, 32'h44);
    drive_m(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0);
    tick();
    chk_buf("zero_after", 1'b0, 5'd0);

    // Reset overrides flush and a side request with the buffer full
    drive_m(1'b1, 5'd3, 2'd0, 32'h33, 32'd0, 2'd0, 3'd0, 32'h500);
    drive_side(1'b1, 5'd10, 32'hAB);
    tick();
    chk_buf("rst_fill", 1'b1, 5'd10);
    reset = 1'b1;
    flush = 1'b1;
    drive_side(1'b1, 5'd11, 32'hCD);
    drive_m(1'b1, 5'd12, 2'd2, 32'h33, 32'd0, 2'd0, 3'd0, 32'h504);
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive_side(1'b0, 5'd0, 32'd0);
    drive_m(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0);
    chk_port("rst_mid", 1'b0, 5'd0, 32'd0);
    chk("rst_mid_pc", out_pc, 32'd0);
    chk_buf("rst_mid", 1'b0, 5'd0);
    tick();
    chk("rst_after_we", 32'(out_we), 32'd0);
    chk_buf("rst_after", 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
